lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/lcd_timing_gen_if.sv | 40 ++++
 rtl/lcd_timing_gen.sv | 208 ++++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_gen_if.sv
// ----------------------------------------------------------------------------
// lcd_timing_gen_if
//   Bundle of the LCD timing generator's run control and panel/pixel outputs.
//
//   Enable       run enable; low acts as a soft reset of the timing
//   LCD_HSYNC    horizontal sync (polarity set by the generator's SYNC_POL)
//   LCD_VSYNC    vertical sync
//   LCD_DE       panel data enable
//   Pixel_X      column of the pixel currently requested (11 bits)
//   Pixel_Y      row of the pixel currently requested (10 bits)
//   Pixel_Req    Pixel_X/Pixel_Y name a visible pixel
//   Frame_Start  one-cycle pulse with the request for pixel (0,0)
//   Line_Start   one-cycle pulse with the request for X=0 of a visible line
//
//   master : the timing generator
//   slave  : the consumer (pixel source / panel side)
// ----------------------------------------------------------------------------
interface lcd_timing_gen_if;
  logic        Enable;
  logic        LCD_HSYNC;
  logic        LCD_VSYNC;
  logic        LCD_DE;
  logic [10:0] Pixel_X;
  logic [9:0]  Pixel_Y;
  logic        Pixel_Req;
  logic        Frame_Start;
  logic        Line_Start;

  modport master (
    input  Enable,
    output LCD_HSYNC, LCD_VSYNC, LCD_DE,
    output Pixel_X, Pixel_Y, Pixel_Req, Frame_Start, Line_Start
  );

  modport slave (
    output Enable,
    input  LCD_HSYNC, LCD_VSYNC, LCD_DE,
    input  Pixel_X, Pixel_Y, Pixel_Req, Frame_Start, Line_Start
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// ----------------------------------------------------------------------------
// lcd_timing_gen
//   Raster timing generator for a parallel RGB LCD panel. A horizontal
//   counter runs 0..H_TOTAL-1 and a vertical counter advances on each
//   horizontal wrap, 0..V_TOTAL-1. Each axis is laid out ACTIVE, FP, SYNC, BP.
//   Every output is registered from the counter state present at the edge,
//   so the first edge after reset release produces pixel (0,0).
//
// Ports
//   PixelClk  pixel clock, sole clock
//   nRST      synchronous active-low reset
//   lcd       lcd_timing_gen_if.master: Enable in; syncs, DE, pixel
//             coordinates, Pixel_Req, Frame_Start, Line_Start out
//
// Configuration
//   LCD_TIMING_LOOKAHEAD_EN  when defined, LCD_DE/LCD_HSYNC/LCD_VSYNC pass
//     through two extra register stages so the pixel request leads the panel
//     timing by exactly two cycles (covers a 2-cycle synchronous image read).
//     When undefined, LCD_DE equals Pixel_Req in the same cycle and the syncs
//     are aligned with the coordinates.
//
// Parameters must satisfy H_TOTAL <= 2048, V_TOTAL <= 1024, each >= 1.
// ----------------------------------------------------------------------------
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 20,
  parameter int H_BP     = 26,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 20,
  parameter int SYNC_POL = 0
) (
  input  logic             PixelClk,
  input  logic             nRST,
  lcd_timing_gen_if.master lcd
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Phase boundaries; each *_END is the first position past that phase.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ACT  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic SYNC_IDLE = ~SYNC_ACT;

  if ((H_TOTAL > 2048) || (V_TOTAL > 1024) ||
      (H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
      (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_params
    $error("lcd_timing_gen: timing parameters out of range");
  end

  // Counter state
  logic [10:0] h_r;
  logic [9:0]  v_r;

  // Combinational next state / decode
  logic [10:0] h_nxt_s;
  logic [9:0]  v_nxt_s;
  logic        vis_s;
  logic [10:0] x_nxt_s;
  logic [9:0]  y_nxt_s;
  logic        fs_nxt_s;
  logic        ls_nxt_s;
  logic        hs_nxt_s;
  logic        vs_nxt_s;

  // Registered outputs
  logic        req_r;
  logic [10:0] x_r;
  logic [9:0]  y_r;
  logic        fs_r;
  logic        ls_r;
  logic        de_r;
  logic        hs_r;
  logic        vs_r;

  // Soft reset: either the hard reset or a dropped Enable restarts the raster.
  logic        clr_s;
  assign clr_s = (!nRST) || (!lcd.Enable);

  // Counter advance: h wraps at H_TOTAL, v steps once per h wrap.
  always_comb begin
    h_nxt_s = h_r;
    v_nxt_s = v_r;
    if (h_r == H_LAST) begin
      h_nxt_s = 11'd0;
      if (v_r == V_LAST) begin
        v_nxt_s = 10'd0;
      end else begin
        v_nxt_s = v_r + 10'd1;
      end
    end else begin
      h_nxt_s = h_r + 11'd1;
      v_nxt_s = v_r;
    end
  end

  // Decode of the current position into the values registered this edge.
  always_comb begin
    vis_s    = (h_r < H_ACT_END) && (v_r < V_ACT_END);
    x_nxt_s  = 11'd0;
    y_nxt_s  = 10'd0;
    fs_nxt_s = 1'b0;
    ls_nxt_s = 1'b0;
    if (vis_s) begin
      x_nxt_s  = h_r;
      y_nxt_s  = v_r;
      ls_nxt_s = (h_r == 11'd0);
      fs_nxt_s = (h_r == 11'd0) && (v_r == 10'd0);
    end else begin
      x_nxt_s  = 11'd0;
      y_nxt_s  = 10'd0;
      ls_nxt_s = 1'b0;
      fs_nxt_s = 1'b0;
    end
    // VSYNC depends on v only, so it switches on the edge that emits h=0.
    if ((h_r >= H_SYNC_BEG) && (h_r < H_SYNC_END)) begin
      hs_nxt_s = SYNC_ACT;
    end else begin
      hs_nxt_s = SYNC_IDLE;
    end
    if ((v_r >= V_SYNC_BEG) && (v_r < V_SYNC_END)) begin
      vs_nxt_s = SYNC_ACT;
    end else begin
      vs_nxt_s = SYNC_IDLE;
    end
  end

  // Counters and first output register stage.
  always_ff @(posedge PixelClk) begin
    if (clr_s) begin
      h_r   <= 11'd0;
      v_r   <= 10'd0;
      req_r <= 1'b0;
      x_r   <= 11'd0;
      y_r   <= 10'd0;
      fs_r  <= 1'b0;
      ls_r  <= 1'b0;
      de_r  <= 1'b0;
      hs_r  <= SYNC_IDLE;
      vs_r  <= SYNC_IDLE;
    end else begin
      h_r   <= h_nxt_s;
      v_r   <= v_nxt_s;
      req_r <= vis_s;
      x_r   <= x_nxt_s;
      y_r   <= y_nxt_s;
      fs_r  <= fs_nxt_s;
      ls_r  <= ls_nxt_s;
      de_r  <= vis_s;
      hs_r  <= hs_nxt_s;
      vs_r  <= vs_nxt_s;
    end
  end

  assign lcd.Pixel_Req   = req_r;
  assign lcd.Pixel_X     = x_r;
  assign lcd.Pixel_Y     = y_r;
  assign lcd.Frame_Start = fs_r;
  assign lcd.Line_Start  = ls_r;

`ifdef LCD_TIMING_LOOKAHEAD_EN
  logic de_d1_r;
  logic de_d2_r;
  logic hs_d1_r;
  logic hs_d2_r;
  logic vs_d1_r;
  logic vs_d2_r;

  // Two-stage delay of the panel timing so pixel data fetched on the request has time to arrive.
  always_ff @(posedge PixelClk) begin
    if (clr_s) begin
      de_d1_r <= 1'b0;
      de_d2_r <= 1'b0;
      hs_d1_r <= SYNC_IDLE;
      hs_d2_r <= SYNC_IDLE;
      vs_d1_r <= SYNC_IDLE;
      vs_d2_r <= SYNC_IDLE;
    end else begin
      de_d1_r <= de_r;
      de_d2_r <= de_d1_r;
      hs_d1_r <= hs_r;
      hs_d2_r <= hs_d1_r;
      vs_d1_r <= vs_r;
      vs_d2_r <= vs_d1_r;
    end
  end

  assign lcd.LCD_DE    = de_d2_r;
  assign lcd.LCD_HSYNC = hs_d2_r;
  assign lcd.LCD_VSYNC = vs_d2_r;
`else
  assign lcd.LCD_DE    = de_r;
  assign lcd.LCD_HSYNC = hs_r;
  assign lcd.LCD_VSYNC = vs_r;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_lcd_timing_gen
//   Two instances: a small raster (16 x 10 total) for whole-frame behaviour
//   and a default-parameter instance for the first lines of a real frame.
//   Small raster: h active 0..7, FP 8..10, sync 11..12, BP 13..15;
//                 v active 0..3, FP 4..5, sync 6..7, BP 8..9; 160 cycles/frame.
//   Cycle n after release shows the decode of linear position k = n-1.
// ----------------------------------------------------------------------------
module tb_lcd_timing_gen;

`ifdef LCD_TIMING_LOOKAHEAD_EN
  localparam int LA = 2;
`else
  localparam int LA = 0;
`endif

  logic clk;
  logic nrst;
  logic en;

  lcd_timing_gen_if lcd_s ();
  lcd_timing_gen_if lcd_d ();
  assign lcd_s.Enable = en;
  assign lcd_d.Enable = en;

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(3), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(0)
  ) u_small (
    .PixelClk(clk),
    .nRST    (nrst),
    .lcd     (lcd_s)
  );

  lcd_timing_gen u_dflt (
    .PixelClk(clk),
    .nRST    (nrst),
    .lcd     (lcd_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Both instances at reset values (syncs idle high).
  task automatic chk_idle(input string tag);
    chk({tag, "_s_de"},  int'(lcd_s.LCD_DE), 0);
    chk({tag, "_s_hs"},  int'(lcd_s.LCD_HSYNC), 1);
    chk({tag, "_s_vs"},  int'(lcd_s.LCD_VSYNC), 1);
    chk({tag, "_s_req"}, int'(lcd_s.Pixel_Req), 0);
    chk({tag, "_s_fs"},  int'(lcd_s.Frame_Start), 0);
    chk({tag, "_s_ls"},  int'(lcd_s.Line_Start), 0);
    chk({tag, "_s_x"},   int'(lcd_s.Pixel_X), 0);
    chk({tag, "_s_y"},   int'(lcd_s.Pixel_Y), 0);
    chk({tag, "_d_de"},  int'(lcd_d.LCD_DE), 0);
    chk({tag, "_d_hs"},  int'(lcd_d.LCD_HSYNC), 1);
    chk({tag, "_d_vs"},  int'(lcd_d.LCD_VSYNC), 1);
    chk({tag, "_d_req"}, int'(lcd_d.Pixel_Req), 0);
    chk({tag, "_d_x"},   int'(lcd_d.Pixel_X), 0);
  endtask

  // Restart at (0,0) with Frame_Start on both instances; DE follows after LA.
  task automatic chk_restart(input string tag);
    for (int m = 1; m <= 3; m++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d_s_req", tag, m), int'(lcd_s.Pixel_Req), 1);
      chk($sformatf("%s_c%0d_s_x", tag, m),   int'(lcd_s.Pixel_X), m - 1);
      chk($sformatf("%s_c%0d_s_y", tag, m),   int'(lcd_s.Pixel_Y), 0);
      chk($sformatf("%s_c%0d_s_fs", tag, m),  int'(lcd_s.Frame_Start), (m == 1) ? 1 : 0);
      chk($sformatf("%s_c%0d_s_ls", tag, m),  int'(lcd_s.Line_Start), (m == 1) ? 1 : 0);
      chk($sformatf("%s_c%0d_s_de", tag, m),  int'(lcd_s.LCD_DE), (m > LA) ? 1 : 0);
      chk($sformatf("%s_c%0d_d_fs", tag, m),  int'(lcd_d.Frame_Start), (m == 1) ? 1 : 0);
      chk($sformatf("%s_c%0d_d_x", tag, m),   int'(lcd_d.Pixel_X), m - 1);
    end
  endtask

  typedef struct {
    int cyc;
    int req, de, hs, vs, fs, ls;
    int x, y;
  } vec_t;

  vec_t tbl[15];

  // Scan bookkeeping
  int fs_cnt, fs_last, ls_cnt, s_de_cnt, s_vs_cnt, s_vs_first, s_hs_cnt, s_hs_first;
  int d_de_cnt, d_hs_cnt, d_hs_first;
  int req_hist[0:400];

  initial begin
    //          cyc  req de hs vs fs ls  x  y
    tbl[0]  = '{  1,  1, 1, 1, 1, 1, 1, 0, 0};
    tbl[1]  = '{  2,  1, 1, 1, 1, 0, 0, 1, 0};
    tbl[2]  = '{  8,  1, 1, 1, 1, 0, 0, 7, 0};
    tbl[3]  = '{  9,  0, 0, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{ 12,  0, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{ 13,  0, 0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{ 14,  0, 0, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{ 17,  1, 1, 1, 1, 0, 1, 0, 1};
    tbl[8]  = '{ 52,  1, 1, 1, 1, 0, 0, 3, 3};
    tbl[9]  = '{ 65,  0, 0, 1, 1, 0, 0, 0, 0};
    tbl[10] = '{ 97,  0, 0, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{108,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{128,  0, 0, 1, 0, 0, 0, 0, 0};
    tbl[13] = '{129,  0, 0, 1, 1, 0, 0, 0, 0};
    tbl[14] = '{161,  1, 1, 1, 1, 1, 1, 0, 0};

    fs_cnt = 0; fs_last = 0; ls_cnt = 0; s_de_cnt = 0; s_vs_cnt = 0; s_vs_first = 0;
    s_hs_cnt = 0; s_hs_first = 0; d_de_cnt = 0; d_hs_cnt = 0; d_hs_first = 0;

    nrst = 1'b0;
    en   = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");

    nrst = 1'b1;
    for (int n = 1, ti = 0; n <= 1100; n++) begin
      @(negedge clk);

      // Directed vectors on the small raster
      if ((ti < 15) && (tbl[ti].cyc == n)) begin
        chk($sformatf("tbl%0d_req", n), int'(lcd_s.Pixel_Req), tbl[ti].req);
        chk($sformatf("tbl%0d_fs", n),  int'(lcd_s.Frame_Start), tbl[ti].fs);
        chk($sformatf("tbl%0d_ls", n),  int'(lcd_s.Line_Start), tbl[ti].ls);
        chk($sformatf("tbl%0d_x", n),   int'(lcd_s.Pixel_X), tbl[ti].x);
        chk($sformatf("tbl%0d_y", n),   int'(lcd_s.Pixel_Y), tbl[ti].y);
`ifndef LCD_TIMING_LOOKAHEAD_EN
        chk($sformatf("tbl%0d_de", n),  int'(lcd_s.LCD_DE), tbl[ti].de);
        chk($sformatf("tbl%0d_hs", n),  int'(lcd_s.LCD_HSYNC), tbl[ti].hs);
        chk($sformatf("tbl%0d_vs", n),  int'(lcd_s.LCD_VSYNC), tbl[ti].vs);
`endif
        ti++;
      end

      // Small raster frame-level scans
      if (lcd_s.Frame_Start) begin
        if (fs_cnt > 0) chk("fs_period", n - fs_last, 160);
        fs_cnt++;
        fs_last = n;
      end
      if ((n <= 160) && lcd_s.Line_Start) ls_cnt++;
      if ((n >= 1 + LA) && (n <= 160 + LA)) begin
        if (lcd_s.LCD_DE) s_de_cnt++;
        if (!lcd_s.LCD_VSYNC) begin
          if (s_vs_cnt == 0) s_vs_first = n;
          s_vs_cnt++;
        end
      end
      if ((n >= 1 + LA) && (n <= 16 + LA) && !lcd_s.LCD_HSYNC) begin
        if (s_hs_cnt == 0) s_hs_first = n;
        s_hs_cnt++;
      end
      if (n <= 400) req_hist[n] = int'(lcd_s.Pixel_Req);
`ifdef LCD_TIMING_LOOKAHEAD_EN
      if (n <= 330) chk($sformatf("la_de_%0d", n), int'(lcd_s.LCD_DE), (n > 2) ? req_hist[n - 2] : 0);
`endif

      // Default-parameter instance, first line and start of second
      if (n == 1) begin
        chk("d_c1_req", int'(lcd_d.Pixel_Req), 1);
        chk("d_c1_fs",  int'(lcd_d.Frame_Start), 1);
        chk("d_c1_x",   int'(lcd_d.Pixel_X), 0);
        chk("d_c1_y",   int'(lcd_d.Pixel_Y), 0);
      end
      if (n == 1 + LA)   chk("d_de_first", int'(lcd_d.LCD_DE), 1);
      if (n == 800)      chk("d_c800_x", int'(lcd_d.Pixel_X), 799);
      if (n == 801)      chk("d_c801_req", int'(lcd_d.Pixel_Req), 0);
      if (n == 800 + LA) chk("d_c800_de", int'(lcd_d.LCD_DE), 1);
      if (n == 801 + LA) chk("d_c801_de", int'(lcd_d.LCD_DE), 0);
      if (n == 1057) begin
        chk("d_line1_y",  int'(lcd_d.Pixel_Y), 1);
        chk("d_line1_ls", int'(lcd_d.Line_Start), 1);
      end
      if ((n >= 1 + LA) && (n <= 1056 + LA)) begin
        if (lcd_d.LCD_DE) d_de_cnt++;
        if (!lcd_d.LCD_HSYNC) begin
          if (d_hs_cnt == 0) d_hs_first = n;
          d_hs_cnt++;
        end
      end
    end

    chk("fs_count", fs_cnt, 7);
    chk("ls_per_frame", ls_cnt, 4);
    chk("s_de_per_frame", s_de_cnt, 32);
    chk("s_vs_low_cycles", s_vs_cnt, 32);
    chk("s_vs_first", s_vs_first, 97 + LA);
    chk("s_hs_low_cycles", s_hs_cnt, 2);
    chk("s_hs_first", s_hs_first, 12 + LA);
    chk("d_de_per_line", d_de_cnt, 800);
    chk("d_hs_low_cycles", d_hs_cnt, 20);
    chk("d_hs_first", d_hs_first, 1011 + LA);

    // One-cycle reset mid-frame (small raster in vertical back porch, h in sync)
    nrst = 1'b0;
    @(negedge clk);
    chk_idle("midrst");
    nrst = 1'b1;
    chk_restart("rst_restart");

    // Run to small-raster v=6,h=11 (both syncs active), then drop Enable 5 cycles
    repeat (105) @(negedge clk);
`ifndef LCD_TIMING_LOOKAHEAD_EN
    chk("pre_en_hs", int'(lcd_s.LCD_HSYNC), 0);
    chk("pre_en_vs", int'(lcd_s.LCD_VSYNC), 0);
`endif
    chk("pre_en_y_blank", int'(lcd_s.Pixel_Req), 0);
    en = 1'b0;
    for (int m = 1; m <= 5; m++) begin
      @(negedge clk);
      chk_idle($sformatf("en_off%0d", m));
    end
    en = 1'b1;
    chk_restart("en_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
